// File: rtl/instr_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// SeqPkg
//   Shared types for the multi-cycle instruction sequencer: state encoding,
//   trap cause codes and an opcode legality helper.
// -----------------------------------------------------------------------------
package SeqPkg;

    import InstrTypes::*;

    typedef enum logic [2:0] {
        BOOT,
        FETCH,
        DECODE,
        MEM,
        WB,
        HALT,
        TRAP
    } seq_state_t;

    localparam logic [1:0] TRAP_NONE    = 2'd0;
    localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
    localparam logic [1:0] TRAP_IMEM_TO = 2'd2;
    localparam logic [1:0] TRAP_DMEM_TO = 2'd3;

    function automatic logic is_legal_op(input logic [6:0] op);
        case (op)
            OP_R, OP_I_LD, OP_S, OP_I_IMM, OP_JALR,
            OP_B, OP_LUI, OP_AUIPC, OP_J: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_types_pkg.sv
// -----------------------------------------------------------------------------
// InstrTypes
//   RV32I major opcode constants (bits [6:0] of the instruction word).
//   Shared by the control unit and the instruction sequencer.
// -----------------------------------------------------------------------------
package InstrTypes;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I_LD  = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_I_IMM = 7'b0010011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_J     = 7'b1101111;

endpackage

// File: rtl/instr_sequencer_perf_counters.sv
// -----------------------------------------------------------------------------
// seq_perf_counters
//   Free-running 32-bit cycle and retired-instruction counters; both wrap.
//   Only instantiated when SEQ_PERF_CNT_EN is defined.
// Ports
//   clk, rst_n      clock, async active-low reset
//   i_active        count this cycle (sequencer not in BOOT/HALT/TRAP)
//   i_retire        one instruction retired this cycle (pc_en)
//   o_cycle_cnt     active cycle count
//   o_instret_cnt   retired instruction count
// -----------------------------------------------------------------------------
module seq_perf_counters (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_active,
    input  logic        i_retire,
    output logic [31:0] o_cycle_cnt,
    output logic [31:0] o_instret_cnt
);

    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instret_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            if (i_active) r_cycle_cnt   <= r_cycle_cnt + 32'd1;
            if (i_retire) r_instret_cnt <= r_instret_cnt + 32'd1;
        end
    end

    assign o_cycle_cnt   = r_cycle_cnt;
    assign o_instret_cnt = r_instret_cnt;

endmodule

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//   Multi-cycle sequencer for the RV32I datapath. Steps each instruction
//   through FETCH / DECODE / MEM / WB, runs the req/ack handshakes to
//   instruction and data memory, and gates reg-write / PC-update so each
//   fires at most once per instruction.
//
//   state  | meaning
//   BOOT   | one idle cycle after reset, all outputs 0
//   FETCH  | imem_req until imem_ack; ir_en on the ack cycle
//   DECODE | classify latched opcode: illegal -> TRAP, ld/st -> MEM, else WB
//   MEM    | dmem_req until dmem_ack; a store retires on the ack cycle
//   WB     | rf_we (from control) and pc_en, instruction retires
//   HALT   | halted, no requests, leaves when halt_req drops
//   TRAP   | sticky trap, leaves only through rst_n
//
// Parameters
//   MEM_TIMEOUT   max wait cycles for an ack before a bus-timeout trap
//                 (0 disables the timeout)
// Ports
//   clk, rst_n              clock, async active-low reset
//   halt_req                stop at the next instruction boundary
//   imem_req/imem_ack       instruction fetch handshake, ir_en latches IR
//   opcode, ctl_reg_write   latched IR opcode and control-unit regWrite
//   dmem_req/dmem_we/ack    data memory handshake (we=1 store)
//   rf_we, pc_en            gated register-file write and PC update
//   halted, trap,trap_cause status; cause 0 none, 1 illegal, 2 imem, 3 dmem
// Configuration
//   SEQ_PERF_CNT_EN adds cycle_cnt[31:0] / instret_cnt[31:0] outputs.
// -----------------------------------------------------------------------------
module instr_sequencer
    import SeqPkg::*;
    import InstrTypes::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       halt_req,
    output logic       imem_req,
    input  logic       imem_ack,
    output logic       ir_en,
    input  logic [6:0] opcode,
    input  logic       ctl_reg_write,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ack,
    output logic       rf_we,
    output logic       pc_en,
    output logic       halted,
    output logic       trap,
    output logic [1:0] trap_cause
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    // A zero-width counter is illegal, so the disabled case keeps one bit.
    localparam int TO_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

    seq_state_t      r_state;
    seq_state_t      w_state_nxt;
    logic [TO_W-1:0] r_wait_cnt;
    logic [1:0]      r_trap_cause;
    logic [1:0]      w_cause_nxt;
    logic            w_timeout;
    logic            w_wait_inc;
    logic            w_is_store;
    logic            w_is_load;

    assign w_is_store = (opcode == OP_S);
    assign w_is_load  = (opcode == OP_I_LD);
    assign w_timeout  = (MEM_TIMEOUT != 0) && (r_wait_cnt == TO_LIMIT);
    assign w_wait_inc = ((r_state == FETCH) && !imem_ack) ||
                        ((r_state == MEM)   && !dmem_ack);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= BOOT;
            r_wait_cnt   <= '0;
            r_trap_cause <= TRAP_NONE;
        end else begin
            r_state      <= w_state_nxt;
            r_trap_cause <= w_cause_nxt;
            // Any state change clears the counter, which covers entry to FETCH/MEM.
            if (w_state_nxt != r_state)
                r_wait_cnt <= '0;
            else if (w_wait_inc)
                r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_trap_cause;
        imem_req    = 1'b0;
        ir_en       = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        rf_we       = 1'b0;
        pc_en       = 1'b0;
        halted      = 1'b0;
        trap        = 1'b0;
        case (r_state)
            BOOT: w_state_nxt = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                // Ack on the timeout cycle still wins.
                if (imem_ack) begin
                    ir_en       = 1'b1;
                    w_state_nxt = DECODE;
                end else if (w_timeout) begin
                    w_state_nxt = TRAP;
                    w_cause_nxt = TRAP_IMEM_TO;
                end
            end
            DECODE: begin
                if (!is_legal_op(opcode)) begin
                    w_state_nxt = TRAP;
                    w_cause_nxt = TRAP_ILLEGAL;
                end else if (w_is_load || w_is_store) begin
                    w_state_nxt = MEM;
                end else begin
                    w_state_nxt = WB;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = w_is_store;
                if (dmem_ack) begin
                    if (w_is_store) begin
                        pc_en       = 1'b1;
                        w_state_nxt = halt_req ? HALT : FETCH;
                    end else begin
                        w_state_nxt = WB;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = TRAP;
                    w_cause_nxt = TRAP_DMEM_TO;
                end
            end
            WB: begin
                rf_we       = ctl_reg_write;
                pc_en       = 1'b1;
                w_state_nxt = halt_req ? HALT : FETCH;
            end
            HALT: begin
                halted = 1'b1;
                if (!halt_req) w_state_nxt = FETCH;
            end
            TRAP:    trap = 1'b1;
            default: w_state_nxt = BOOT;
        endcase
    end

    assign trap_cause = r_trap_cause;

`ifdef SEQ_PERF_CNT_EN
    logic w_active;
    assign w_active = (r_state != BOOT) && (r_state != HALT) && (r_state != TRAP);

    seq_perf_counters u_perf (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_active      (w_active),
        .i_retire      (pc_en),
        .o_cycle_cnt   (cycle_cnt),
        .o_instret_cnt (instret_cnt)
    );
`else
    // Performance counters not built.
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;
    import InstrTypes::*;

    localparam logic [9:0] E_IREQ = 10'b10_0000_0000;
    localparam logic [9:0] E_IREN = 10'b01_0000_0000;
    localparam logic [9:0] E_DREQ = 10'b00_1000_0000;
    localparam logic [9:0] E_DWE  = 10'b00_0100_0000;
    localparam logic [9:0] E_RFWE = 10'b00_0010_0000;
    localparam logic [9:0] E_PCEN = 10'b00_0001_0000;
    localparam logic [9:0] E_HALT = 10'b00_0000_1000;
    localparam logic [9:0] E_TRAP = 10'b00_0000_0100;
    localparam logic [9:0] E_NONE = 10'b00_0000_0000;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    typedef struct {
        logic       rst;
        logic       hr;
        logic       ia;
        logic [6:0] op;
        logic       crw;
        logic       da;
        logic [9:0] ex;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       halt_req;
    logic       imem_req;
    logic       imem_ack;
    logic       ir_en;
    logic [6:0] opcode;
    logic       ctl_reg_write;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ack;
    logic       rf_we;
    logic       pc_en;
    logic       halted;
    logic       trap;
    logic [1:0] trap_cause;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;
`endif
    logic [9:0] w_out;

    int n_vec = 0;
    int n_err = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    instr_sequencer #(.MEM_TIMEOUT(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .halt_req      (halt_req),
        .imem_req      (imem_req),
        .imem_ack      (imem_ack),
        .ir_en         (ir_en),
        .opcode        (opcode),
        .ctl_reg_write (ctl_reg_write),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_ack      (dmem_ack),
        .rf_we         (rf_we),
        .pc_en         (pc_en),
        .halted        (halted),
        .trap          (trap),
        .trap_cause    (trap_cause)
`ifdef SEQ_PERF_CNT_EN
        ,
        .cycle_cnt     (cycle_cnt),
        .instret_cnt   (instret_cnt)
`endif
    );

    assign w_out = {imem_req, ir_en, dmem_req, dmem_we, rf_we, pc_en,
                    halted, trap, trap_cause};

    function automatic vec_t mk(input logic rst, input logic hr, input logic ia,
                                input logic [6:0] op, input logic crw,
                                input logic da, input logic [9:0] ex);
        vec_t v;
        v.rst = rst; v.hr = hr; v.ia = ia; v.op = op;
        v.crw = crw; v.da = da; v.ex = ex;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [9:0] got, input logic [9:0] ex);
        n_vec++;
        if (got !== ex) begin
            n_err++;
            $display("FAIL %s: outputs {ireq,iren,dreq,dwe,rfwe,pcen,halt,trap,cause}=%b expected %b",
                     nm, got, ex);
        end
    endtask

    // Drive inputs just after a rising edge, compare mid-cycle, advance one cycle.
    task automatic apply(input vec_t v, input string nm);
        rst_n         = v.rst;
        halt_req      = v.hr;
        imem_ack      = v.ia;
        opcode        = v.op;
        ctl_reg_write = v.crw;
        dmem_ack      = v.da;
        @(negedge clk);
        chk(nm, w_out, v.ex);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; halt_req = 1'b0; imem_ack = 1'b0; opcode = OP_I_IMM;
        ctl_reg_write = 1'b0; dmem_ack = 1'b0;
        #2;
        chk("reset_state", w_out, E_NONE);
        @(posedge clk);
        #1;

        // ADDI, zero-wait fetch
        tbl.push_back(mk(1, 0, 1, OP_I_IMM, 1, 1, E_NONE));              // c0 BOOT, acks ignored
        tbl.push_back(mk(1, 0, 1, OP_I_IMM, 1, 0, E_IREQ | E_IREN));     // c1 FETCH
        tbl.push_back(mk(1, 0, 0, OP_I_IMM, 1, 0, E_NONE));              // c2 DECODE
        tbl.push_back(mk(1, 0, 0, OP_I_IMM, 1, 0, E_RFWE | E_PCEN));     // c3 WB
        tbl.push_back(mk(1, 0, 0, OP_I_IMM, 1, 0, E_IREQ));              // c4 FETCH wait
        // LW with two data wait cycles
        tbl.push_back(mk(1, 0, 1, OP_I_LD, 1, 0, E_IREQ | E_IREN));
        tbl.push_back(mk(1, 0, 0, OP_I_LD, 1, 0, E_NONE));
        tbl.push_back(mk(1, 0, 0, OP_I_LD, 1, 0, E_DREQ));
        tbl.push_back(mk(1, 0, 0, OP_I_LD, 1, 0, E_DREQ));
        tbl.push_back(mk(1, 0, 0, OP_I_LD, 1, 1, E_DREQ));
        tbl.push_back(mk(1, 0, 0, OP_I_LD, 1, 0, E_RFWE | E_PCEN));
        // SW, immediate ack; regWrite high must not leak to rf_we
        tbl.push_back(mk(1, 0, 1, OP_S, 1, 0, E_IREQ | E_IREN));
        tbl.push_back(mk(1, 0, 0, OP_S, 1, 0, E_NONE));
        tbl.push_back(mk(1, 0, 0, OP_S, 1, 1, E_DREQ | E_DWE | E_PCEN));
        tbl.push_back(mk(1, 0, 0, OP_S, 1, 0, E_IREQ));
        // Illegal opcode
        tbl.push_back(mk(1, 0, 1, OP_BAD, 1, 0, E_IREQ | E_IREN));
        tbl.push_back(mk(1, 0, 0, OP_BAD, 1, 0, E_NONE));
        tbl.push_back(mk(1, 0, 1, OP_BAD, 1, 1, E_TRAP | 10'd1));
        tbl.push_back(mk(1, 1, 0, OP_BAD, 1, 0, E_TRAP | 10'd1));
        tbl.push_back(mk(0, 0, 0, OP_BAD, 0, 0, E_NONE));
        tbl.push_back(mk(1, 0, 1, OP_B, 0, 1, E_NONE));                  // BOOT after release
        // Branch with regWrite low
        tbl.push_back(mk(1, 0, 1, OP_B, 0, 0, E_IREQ | E_IREN));
        tbl.push_back(mk(1, 0, 0, OP_B, 0, 0, E_NONE));
        tbl.push_back(mk(1, 0, 0, OP_B, 0, 0, E_PCEN));
        tbl.push_back(mk(1, 0, 0, OP_B, 0, 0, E_IREQ));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Fetch timeout: five FETCH cycles with no ack -> cause 2
        apply(mk(0, 0, 0, OP_I_IMM, 0, 0, E_NONE), "t5_rst");
        apply(mk(1, 0, 0, OP_I_IMM, 0, 0, E_NONE), "t5_boot");
        for (int k = 0; k < 5; k++)
            apply(mk(1, 0, 0, OP_I_IMM, 0, 0, E_IREQ), $sformatf("t5_fetch_wait%0d", k));
        apply(mk(1, 0, 0, OP_I_IMM, 0, 0, E_TRAP | 10'd2), "t5_imem_to");
        // Ack on the fifth cycle beats the timeout
        apply(mk(0, 0, 0, OP_I_IMM, 0, 0, E_NONE), "t5b_rst");
        apply(mk(1, 0, 0, OP_I_IMM, 0, 0, E_NONE), "t5b_boot");
        for (int k = 0; k < 4; k++)
            apply(mk(1, 0, 0, OP_I_IMM, 0, 0, E_IREQ), $sformatf("t5b_fetch_wait%0d", k));
        apply(mk(1, 0, 1, OP_I_IMM, 0, 0, E_IREQ | E_IREN), "t5b_ack_at_limit");
        apply(mk(1, 0, 0, OP_I_IMM, 0, 0, E_NONE), "t5b_decode");
        apply(mk(1, 0, 0, OP_I_IMM, 0, 0, E_PCEN), "t5b_wb");
        // Data timeout on a load -> cause 3
        apply(mk(1, 0, 1, OP_I_LD, 1, 0, E_IREQ | E_IREN), "t5c_fetch");
        apply(mk(1, 0, 0, OP_I_LD, 1, 0, E_NONE), "t5c_decode");
        for (int k = 0; k < 5; k++)
            apply(mk(1, 0, 0, OP_I_LD, 1, 0, E_DREQ), $sformatf("t5c_mem_wait%0d", k));
        apply(mk(1, 0, 0, OP_I_LD, 1, 0, E_TRAP | 10'd3), "t5c_dmem_to");

        // Halt requested during a load's MEM wait
        apply(mk(0, 0, 0, OP_I_LD, 1, 0, E_NONE), "t6_rst");
        apply(mk(1, 0, 0, OP_I_LD, 1, 0, E_NONE), "t6_boot");
        apply(mk(1, 0, 1, OP_I_LD, 1, 0, E_IREQ | E_IREN), "t6_fetch");
        apply(mk(1, 0, 0, OP_I_LD, 1, 0, E_NONE), "t6_decode");
        apply(mk(1, 1, 0, OP_I_LD, 1, 0, E_DREQ), "t6_mem_wait0");
        apply(mk(1, 1, 0, OP_I_LD, 1, 0, E_DREQ), "t6_mem_wait1");
        apply(mk(1, 1, 0, OP_I_LD, 1, 1, E_DREQ), "t6_mem_ack");
        apply(mk(1, 1, 0, OP_I_LD, 1, 0, E_RFWE | E_PCEN), "t6_wb");
        apply(mk(1, 1, 0, OP_I_LD, 1, 0, E_HALT), "t6_halt0");
        apply(mk(1, 1, 1, OP_I_LD, 1, 1, E_HALT), "t6_halt_ack_ignored");
        apply(mk(1, 0, 0, OP_I_LD, 1, 0, E_HALT), "t6_halt_release");
        // Now in FETCH: pulse reset mid-cycle, outputs must drop without a clock edge
        #1;
        chk("t6_fetch_before_rst", w_out, E_IREQ);
        rst_n = 1'b0;
        #1;
        chk("t6_async_rst", w_out, E_NONE);
        @(posedge clk);
        #1;
        apply(mk(1, 0, 1, OP_I_LD, 1, 1, E_NONE), "t6_boot_after_rst");
        apply(mk(1, 0, 0, OP_I_LD, 1, 0, E_IREQ), "t6_fetch_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
